// File: rtl/ascon_aead128_ctrl.sv
// Host-side sequencer for ascon_aead128_core: turns one command plus a stream of
// AD/data blocks into the core's start/key/nonce/valid protocol and checks the tag.
module ascon_aead128_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_decrypt,
  input  logic [127:0]     cmd_key,
  input  logic [127:0]     cmd_nonce,
  input  logic [CNT_W-1:0] cmd_n_ad,
  input  logic [CNT_W-1:0] cmd_n_db,
  input  logic [127:0]     cmd_exp_tag,
  output logic             cmd_error,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  output logic [127:0]     out_data,
  output logic             tag_valid,
  output logic             tag_ok,
  output logic             done,
  output logic             core_start,
  output logic             core_valid_ad,
  output logic             core_valid_db_in,
  output logic [127:0]     core_ad,
  output logic [127:0]     core_db,
  output logic [127:0]     core_key,
  output logic [127:0]     core_nonce,
  input  logic             core_ready,
  input  logic             core_valid_db_out,
  input  logic             core_valid_tag,
  input  logic [127:0]     core_dout
);

  typedef enum logic [2:0] {
    IDLE, START, KEYNONCE, AD_WAIT, AD_PULSE, DB_WAIT, DB_PULSE, TAG_WAIT
  } state_t;

  state_t           state, state_nx;
  logic [127:0]     key_r, nonce_r, exp_tag_r, ad_r, db_r;
  logic             dec_r, ready_r, start_r, rdy_q, rdy_seen;
  logic [CNT_W-1:0] n_ad_r, n_db_r, cnt;
  logic             cmd_acc, cmd_bad, hs, rdy_edge, start_drop, tag_fire, dout_fire;

  assign cmd_acc   = cmd_valid & ready_r;
  assign cmd_bad   = (cmd_n_ad == '0) || (cmd_n_db == '0);
  assign in_ready  = rdy_seen & ((state == AD_WAIT) || (state == DB_WAIT));
  assign hs        = in_valid & in_ready;
  assign rdy_edge  = core_ready & ~rdy_q;
  assign tag_fire  = (state == TAG_WAIT) & core_valid_tag;
  assign dout_fire = (state != IDLE) & core_valid_db_out;

  always_comb begin
    state_nx   = state;
    start_drop = 1'b0;
    case (state)
      IDLE:     if (cmd_acc && !cmd_bad) state_nx = START;
      START:    state_nx = KEYNONCE;
      KEYNONCE: state_nx = AD_WAIT;
      AD_WAIT:  if (hs) state_nx = AD_PULSE;
      AD_PULSE: begin
        if (cnt == n_ad_r) begin
          state_nx   = DB_WAIT;
          start_drop = (n_db_r == CNT_W'(1));
        end else begin
          state_nx = AD_WAIT;
        end
      end
      DB_WAIT:  if (hs) state_nx = DB_PULSE;
      DB_PULSE: begin
        if (cnt == n_db_r) begin
          state_nx = TAG_WAIT;
        end else begin
          state_nx   = DB_WAIT;
          start_drop = (cnt == n_db_r - CNT_W'(1));
        end
      end
      TAG_WAIT: if (core_valid_tag) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_r   <= 1'b0;
      cmd_error <= 1'b0;
      key_r     <= '0;
      nonce_r   <= '0;
      exp_tag_r <= '0;
      dec_r     <= 1'b0;
      n_ad_r    <= '0;
      n_db_r    <= '0;
      cnt       <= '0;
      start_r   <= 1'b0;
      rdy_q     <= 1'b0;
      rdy_seen  <= 1'b0;
      ad_r      <= '0;
      db_r      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tag_valid <= 1'b0;
      tag_ok    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      ready_r   <= (state_nx == IDLE);
      cmd_error <= cmd_acc & cmd_bad;
      if (state_nx == START) begin
        key_r     <= cmd_key;
        nonce_r   <= cmd_nonce;
        exp_tag_r <= cmd_exp_tag;
        dec_r     <= cmd_decrypt;
        n_ad_r    <= cmd_n_ad;
        n_db_r    <= cmd_n_db;
      end
      // One counter serves both phases; it restarts when the AD phase completes.
      if (state == IDLE)                         cnt <= '0;
      else if (hs)                               cnt <= cnt + CNT_W'(1);
      else if (state == AD_PULSE && cnt == n_ad_r) cnt <= '0;
      if (state_nx == START) start_r <= 1'b1;
      else if (start_drop)   start_r <= 1'b0;
      rdy_q <= core_ready;
      // A fresh ready edge wins over the clear caused by issuing a block.
      if (state == IDLE)  rdy_seen <= 1'b0;
      else if (rdy_edge)  rdy_seen <= 1'b1;
      else if (hs)        rdy_seen <= 1'b0;
      if (hs && state == AD_WAIT) ad_r <= in_data;
      else if (state != AD_PULSE) ad_r <= '0;
      if (hs && state == DB_WAIT) db_r <= in_data;
      else if (state != DB_PULSE) db_r <= '0;
      out_valid <= dout_fire;
      tag_valid <= tag_fire;
      done      <= tag_fire;
      tag_ok    <= tag_fire & (dec_r ? (core_dout == exp_tag_r) : 1'b1);
      if (dout_fire || tag_fire) out_data <= core_dout;
    end
  end

  assign cmd_ready        = ready_r;
  assign core_start       = start_r;
  assign core_valid_ad    = (state == AD_PULSE);
  assign core_valid_db_in = (state == DB_PULSE);
  assign core_ad          = ad_r;
  assign core_db          = db_r;
  assign core_key         = (state == KEYNONCE) ? key_r : '0;
  assign core_nonce       = (state == KEYNONCE) ? nonce_r : '0;

endmodule
